// File: rtl/frv_pipeline_writeback_pkg.sv
// frv_pipeline_writeback_pkg
//  Shared definitions for the frv writeback stage:
//  - functional-unit bit indices for the one-hot s4_fu bundle field
//  - control-flow and CSR micro-op codes as seen after execute
//  - writeback FSM state type
package frv_pipeline_writeback_pkg;

  // One-hot functional unit bit positions in s4_fu.
  localparam int unsigned P_FU_ALU = 0;
  localparam int unsigned P_FU_MUL = 1;
  localparam int unsigned P_FU_LSU = 2;
  localparam int unsigned P_FU_CFU = 3;
  localparam int unsigned P_FU_CSR = 4;

  // CFU micro-op codes (branches are resolved to TAKEN/NOT_TAKEN by execute).
  localparam logic [4:0] CFU_JMP       = 5'd1;
  localparam logic [4:0] CFU_JALI      = 5'd2;
  localparam logic [4:0] CFU_JALR      = 5'd3;
  localparam logic [4:0] CFU_TAKEN     = 5'd4;
  localparam logic [4:0] CFU_NOT_TAKEN = 5'd5;

  // uop bit marking an LSU store, and a CSR access that writes.
  localparam int unsigned LSU_STORE_BIT = 3;
  localparam int unsigned CSR_WRITE_BIT = 3;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_CF_WAIT,
    WB_TRAP_WAIT
  } wb_state_t;

  function automatic logic cfu_redirects(input logic [4:0] uop);
    return (uop == CFU_TAKEN) || (uop == CFU_JMP) ||
           (uop == CFU_JALI)  || (uop == CFU_JALR);
  endfunction

  function automatic logic cfu_links(input logic [4:0] uop);
    return (uop == CFU_JALI) || (uop == CFU_JALR);
  endfunction

endpackage

// File: rtl/frv_pipeline_writeback.sv
// frv_pipeline_writeback
//  Stage 5 (writeback/commit) of the frv pipeline. Commits the s4_* bundle in
//  zero cycles when idle: GPR write, CSR access, control-flow redirect to
//  fetch and trap hand-off to the control unit. Younger stages are flushed on
//  the commit cycle of a redirecting or trapping instruction, and the stage
//  stays busy until the fetch/control unit acknowledges the request.
// Ports
//  g_clk, g_resetn                    clock, synchronous active-low reset
//  s4_*                               execute-stage bundle, s4_p_busy back-pressure
//  flush                              kill younger stages (combinational)
//  gpr_*, fwd_s4_*                    register-file write port and its forwarding copy
//  csr_en/wr/addr/wdata, csr_rdata/error  CSR request and same-cycle response
//  cf_req/cf_target/cf_ack            redirect handshake to fetch
//  trap_req/trap_pc/trap_ack          trap handshake to control unit
//  instr_ret                          one-cycle retire pulse
//  trace_valid/pc/instr               retirement trace
// Configuration
//  FRV_WB_TRACE_EN  defined: registered retirement trace; undefined: trace tied to 0.
module frv_pipeline_writeback
  import frv_pipeline_writeback_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic [4:0]      s4_rd,
  input  logic [XLEN-1:0] s4_opr_a,
  input  logic [XLEN-1:0] s4_opr_b,
  input  logic [31:0]     s4_pc,
  input  logic [4:0]      s4_uop,
  input  logic [4:0]      s4_fu,
  input  logic            s4_trap,
  input  logic [1:0]      s4_size,
  input  logic [31:0]     s4_instr,
  input  logic            s4_p_valid,
  output logic            s4_p_busy,
  output logic            flush,
  output logic [4:0]      fwd_s4_rd,
  output logic [XLEN-1:0] fwd_s4_wdata,
  output logic            fwd_s4_wen,
  output logic            gpr_wen,
  output logic [4:0]      gpr_rd,
  output logic [XLEN-1:0] gpr_wdata,
  output logic            csr_en,
  output logic            csr_wr,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_error,
  output logic            cf_req,
  output logic [31:0]     cf_target,
  input  logic            cf_ack,
  output logic            trap_req,
  output logic [31:0]     trap_pc,
  input  logic            trap_ack,
  output logic            instr_ret,
  output logic            trace_valid,
  output logic [31:0]     trace_pc,
  output logic [31:0]     trace_instr
);

  wb_state_t r_state, w_next_state;

  logic        w_commit;
  logic        w_trap;
  logic        w_redirect;
  logic [31:0] w_link;
  logic        r_instr_ret;
  logic [31:0] r_cf_target;
  logic [31:0] r_trap_pc;

  assign w_commit   = s4_p_valid && (r_state == WB_IDLE);
  // A CSR fault reported this cycle turns the instruction into a trap.
  assign w_trap     = s4_trap || (s4_fu[P_FU_CSR] && csr_error);
  assign w_redirect = s4_fu[P_FU_CFU] && cfu_redirects(s4_uop) && !w_trap;

  assign s4_p_busy  = (r_state != WB_IDLE);
  assign flush      = w_commit && (w_redirect || w_trap);

  assign csr_en     = w_commit && s4_fu[P_FU_CSR] && !s4_trap;
  assign csr_wr     = csr_en && s4_uop[CSR_WRITE_BIT];
  assign csr_addr   = s4_opr_b[11:0];
  assign csr_wdata  = s4_opr_a;

  // Link-address adder and GPR write-select.
  always_comb begin
    w_link    = s4_pc + ((s4_size == 2'b01) ? 32'd2 : 32'd4);
    gpr_rd    = s4_rd;
    gpr_wdata = s4_opr_a;
    gpr_wen   = 1'b0;
    if (s4_fu[P_FU_CSR]) begin
      gpr_wdata = csr_rdata;
    end else if (s4_fu[P_FU_CFU]) begin
      gpr_wdata = XLEN'(w_link);
    end
    if (w_commit && !w_trap && (s4_rd != 5'd0)) begin
      gpr_wen = s4_fu[P_FU_ALU] || s4_fu[P_FU_MUL] || s4_fu[P_FU_CSR] ||
                (s4_fu[P_FU_LSU] && !s4_uop[LSU_STORE_BIT]) ||
                (s4_fu[P_FU_CFU] && cfu_links(s4_uop));
    end
  end

  assign fwd_s4_rd    = gpr_rd;
  assign fwd_s4_wdata = gpr_wdata;
  assign fwd_s4_wen   = gpr_wen;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WB_IDLE: begin
        if (w_commit && w_trap)          w_next_state = WB_TRAP_WAIT;
        else if (w_commit && w_redirect) w_next_state = WB_CF_WAIT;
      end
      WB_CF_WAIT:   if (cf_ack)   w_next_state = WB_IDLE;
      WB_TRAP_WAIT: if (trap_ack) w_next_state = WB_IDLE;
      default:                    w_next_state = WB_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state     <= WB_IDLE;
      r_instr_ret <= 1'b0;
      r_cf_target <= '0;
      r_trap_pc   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_instr_ret <= w_commit && !w_trap;
      if (w_commit && w_redirect) r_cf_target <= s4_opr_a[31:0];
      if (w_commit && w_trap)     r_trap_pc   <= s4_pc;
    end
  end

  // Requests are the wait states themselves, so they are registered and drop
  // the cycle after the acknowledge.
  assign cf_req    = (r_state == WB_CF_WAIT);
  assign trap_req  = (r_state == WB_TRAP_WAIT);
  assign cf_target = r_cf_target;
  assign trap_pc   = r_trap_pc;
  assign instr_ret = r_instr_ret;

`ifdef FRV_WB_TRACE_EN
  logic        r_trace_valid;
  logic [31:0] r_trace_pc;
  logic [31:0] r_trace_instr;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_trace_valid <= 1'b0;
      r_trace_pc    <= '0;
      r_trace_instr <= '0;
    end else begin
      r_trace_valid <= w_commit && !w_trap;
      if (w_commit) begin
        r_trace_pc    <= s4_pc;
        r_trace_instr <= s4_instr;
      end
    end
  end

  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;
  assign trace_instr = r_trace_instr;

  logic w_unused;
  assign w_unused = ^{s4_opr_b[XLEN-1:12]};
`else
  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign trace_instr = '0;

  logic w_unused;
  assign w_unused = ^{s4_opr_b[XLEN-1:12], s4_instr};
`endif

endmodule
